// File: rtl/cpu_pkg.sv
// Shared CPU definitions: branch sequencer states, flag-select codes and the
// opcode pattern that identifies a 6502 relative branch.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OFFSET = 2'd1,
    ADD    = 2'd2,
    FIX    = 2'd3
  } branch_state_t;

  localparam logic [1:0] FSEL_N = 2'b00;
  localparam logic [1:0] FSEL_V = 2'b01;
  localparam logic [1:0] FSEL_C = 2'b10;
  localparam logic [1:0] FSEL_Z = 2'b11;

  // All eight relative branches share the low opcode bits xxx1_0000.
  localparam logic [4:0] BRANCH_MASK  = 5'h1F;
  localparam logic [4:0] BRANCH_MATCH = 5'h10;

endpackage

// File: rtl/branch_cond.sv
// Combinational branch condition: opcode[7:6] picks N/V/C/Z, opcode[5] is the
// value that flag must have for the branch to be taken.
module branch_cond
  import cpu_pkg::*;
(
  input  logic [2:0] opcode_hi,
  input  logic       flag_n,
  input  logic       flag_v,
  input  logic       flag_c,
  input  logic       flag_z,
  output logic       cond
);

  logic w_sel;

  always_comb begin
    w_sel = flag_n;
    case (opcode_hi[2:1])
      FSEL_N:  w_sel = flag_n;
      FSEL_V:  w_sel = flag_v;
      FSEL_C:  w_sel = flag_c;
      FSEL_Z:  w_sel = flag_z;
      default: w_sel = flag_n;
    endcase
    cond = (w_sel == opcode_hi[0]);
  end

endmodule

// File: rtl/branch_seq.sv
// Relative-branch sequencer: drives PC strobes for 2/3/4-cycle branch timing
// (not taken / taken same page / taken with PCH fix-up).
module branch_seq
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] opcode,
  input  logic       flag_n,
  input  logic       flag_v,
  input  logic       flag_c,
  input  logic       flag_z,
  input  logic [7:0] offset_in,
  input  logic [7:0] pcl_in,
  output logic       pc_l_inc,
  output logic       pc_load_l,
  output logic [7:0] pcl_out,
  output logic       pc_h_inc,
  output logic       pc_h_dec,
  output logic       busy,
  output logic       done,
  output logic       taken,
  output logic       crossed,
  output logic [1:0] dbg_state
);

  branch_state_t r_state;
  logic          r_cond;
  logic [7:0]    r_offset;
  logic          r_taken;
  logic          r_crossed;

  logic          w_cond;
  logic          w_accept;
  logic [8:0]    w_sum9;
  logic          w_cross;

  branch_cond u_cond (
    .opcode_hi (opcode[7:5]),
    .flag_n    (flag_n),
    .flag_v    (flag_v),
    .flag_c    (flag_c),
    .flag_z    (flag_z),
    .cond      (w_cond)
  );

  assign w_accept = start && (r_state == IDLE) &&
                    ((opcode[4:0] & BRANCH_MASK) == BRANCH_MATCH);

  // A carry out of PCL means a page change only for a forward offset; for a
  // negative offset the page changes when there is no carry.
  assign w_sum9  = {1'b0, pcl_in} + {1'b0, r_offset};
  assign w_cross = w_sum9[8] ^ r_offset[7];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cond    <= 1'b0;
      r_offset  <= 8'h00;
      r_taken   <= 1'b0;
      r_crossed <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_cond    <= w_cond;
            r_crossed <= 1'b0;
            r_state   <= OFFSET;
          end
        end
        OFFSET: begin
          r_offset <= offset_in;
          r_taken  <= r_cond;
          r_state  <= r_cond ? ADD : IDLE;
        end
        ADD: begin
          r_crossed <= w_cross;
          r_state   <= w_cross ? FIX : IDLE;
        end
        FIX:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    pc_l_inc  = 1'b0;
    pc_load_l = 1'b0;
    pcl_out   = 8'h00;
    pc_h_inc  = 1'b0;
    pc_h_dec  = 1'b0;
    done      = 1'b0;
    case (r_state)
      OFFSET: begin
        pc_l_inc = 1'b1;
        done     = !r_cond;
      end
      ADD: begin
        pc_load_l = 1'b1;
        pcl_out   = w_sum9[7:0];
        done      = !w_cross;
      end
      FIX: begin
        pc_h_inc = !r_offset[7];
        pc_h_dec = r_offset[7];
        done     = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy      = (r_state != IDLE);
  assign taken     = r_taken;
  assign crossed   = r_crossed;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_branch_seq.sv
// Bench for branch_seq: a PC register model driven by the DUT strobes, an
// instruction-level branch model producing per-cycle expectations, and
// directed branches with hand-computed final PCs and cycle counts.
module tb_branch_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] opcode = 8'h00;
  logic       flag_n = 1'b0, flag_v = 1'b0, flag_c = 1'b0, flag_z = 1'b0;
  logic [7:0] offset_in = 8'h00;
  logic [15:0] pc = 16'h0000;
  logic [7:0] pcl_in;
  logic       pc_l_inc, pc_load_l, pc_h_inc, pc_h_dec;
  logic [7:0] pcl_out;
  logic       busy, done, taken, crossed;
  logic [1:0] dbg_state;

  assign pcl_in = pc[7:0];

  branch_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .opcode    (opcode),
    .flag_n    (flag_n),
    .flag_v    (flag_v),
    .flag_c    (flag_c),
    .flag_z    (flag_z),
    .offset_in (offset_in),
    .pcl_in    (pcl_in),
    .pc_l_inc  (pc_l_inc),
    .pc_load_l (pc_load_l),
    .pcl_out   (pcl_out),
    .pc_h_inc  (pc_h_inc),
    .pc_h_dec  (pc_h_dec),
    .busy      (busy),
    .done      (done),
    .taken     (taken),
    .crossed   (crossed),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct packed {
    logic       l_inc;
    logic       load_l;
    logic [7:0] pcl;
    logic       h_inc;
    logic       h_dec;
    logic       done;
    logic       taken;
    logic       crossed;
  } exp_t;

  exp_t exp_q[$];
  logic m_taken = 1'b0, m_crossed = 1'b0;
  logic f_taken = 1'b0, f_crossed = 1'b0;
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, expv, $time);
    end
  endtask

  // Branch rule by mnemonic; fl = {N,V,C,Z}.
  function automatic logic br_cond(input logic [7:0] op, input logic [3:0] fl);
    case (op)
      8'h10: return !fl[3];  // BPL
      8'h30: return fl[3];   // BMI
      8'h50: return !fl[2];  // BVC
      8'h70: return fl[2];   // BVS
      8'h90: return !fl[1];  // BCC
      8'hB0: return fl[1];   // BCS
      8'hD0: return !fl[0];  // BNE
      8'hF0: return fl[0];   // BEQ
      default: return 1'b0;
    endcase
  endfunction

  // scoreboard: compare at negedge, advance PC model and branch model after posedge
  initial begin
    logic       s_start, s_li, s_ll, s_hi, s_hd;
    logic [7:0] s_op, s_off, s_pcl;
    logic [3:0] s_fl;
    logic [15:0] nxt, tgt;
    logic       cnd, crs;
    exp_t       e, a;
    s_start = 0; s_li = 0; s_ll = 0; s_hi = 0; s_hd = 0;
    s_op = 0; s_off = 0; s_pcl = 0; s_fl = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_l_inc", {15'd0, pc_l_inc}, 16'd0);
        chk("rst_load_l", {15'd0, pc_load_l}, 16'd0);
        chk("rst_pcl_out", {8'd0, pcl_out}, 16'd0);
        chk("rst_h_inc", {15'd0, pc_h_inc}, 16'd0);
        chk("rst_h_dec", {15'd0, pc_h_dec}, 16'd0);
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_done", {15'd0, done}, 16'd0);
        chk("rst_taken", {15'd0, taken}, 16'd0);
        chk("rst_crossed", {15'd0, crossed}, 16'd0);
        exp_q.delete();
        m_taken = 0; m_crossed = 0;
        s_start = 0; s_li = 0; s_ll = 0; s_hi = 0; s_hd = 0;
      end else begin
        e = '0;
        e.taken = m_taken;
        e.crossed = m_crossed;
        if (exp_q.size() > 0) e = exp_q[0];
        chk("busy", {15'd0, busy}, {15'd0, exp_q.size() > 0});
        chk("l_inc", {15'd0, pc_l_inc}, {15'd0, e.l_inc});
        chk("load_l", {15'd0, pc_load_l}, {15'd0, e.load_l});
        chk("pcl_out", {8'd0, pcl_out}, {8'd0, e.pcl});
        chk("h_inc", {15'd0, pc_h_inc}, {15'd0, e.h_inc});
        chk("h_dec", {15'd0, pc_h_dec}, {15'd0, e.h_dec});
        chk("done", {15'd0, done}, {15'd0, e.done});
        chk("taken", {15'd0, taken}, {15'd0, e.taken});
        chk("crossed", {15'd0, crossed}, {15'd0, e.crossed});
        s_start = start; s_op = opcode; s_off = offset_in;
        s_fl = {flag_n, flag_v, flag_c, flag_z};
        s_li = pc_l_inc; s_ll = pc_load_l; s_pcl = pcl_out;
        s_hi = pc_h_inc; s_hd = pc_h_dec;
      end
      @(posedge clk);
      #1;
      if (s_li) pc = pc + 16'd1;
      if (s_ll) pc[7:0] = s_pcl;
      if (s_hi) pc[15:8] = pc[15:8] + 8'd1;
      if (s_hd) pc[15:8] = pc[15:8] - 8'd1;
      s_li = 0; s_ll = 0; s_hi = 0; s_hd = 0;
      if (exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) begin
          m_taken = f_taken;
          m_crossed = f_crossed;
        end
      end else if (s_start && s_op[4:0] == 5'h10 && rst_n) begin
        nxt = pc + 16'd1;
        tgt = nxt + {{8{s_off[7]}}, s_off};
        cnd = br_cond(s_op, s_fl);
        crs = cnd && (tgt[15:8] != nxt[15:8]);
        a = '0; a.l_inc = 1; a.done = !cnd; a.taken = m_taken;
        exp_q.push_back(a);
        if (cnd) begin
          a = '0; a.load_l = 1; a.pcl = tgt[7:0]; a.done = !crs; a.taken = 1;
          exp_q.push_back(a);
          if (crs) begin
            a = '0; a.h_inc = (s_off < 8'h80); a.h_dec = (s_off >= 8'h80);
            a.done = 1; a.taken = 1; a.crossed = 1;
            exp_q.push_back(a);
          end
        end
        f_taken = cnd;
        f_crossed = crs;
        m_crossed = 1'b0;
      end
      s_start = 0;
    end
  end

  // driver: one branch, optional extra start in cycle extra (T0 = cycle 1)
  task automatic run_branch(input string name, input logic [7:0] op, input logic [3:0] fl,
                            input logic [15:0] pc0, input logic [7:0] off,
                            input logic [15:0] exp_pc, input int exp_cyc,
                            input logic exp_taken, input logic exp_crossed, input int extra);
    int   cyc;
    logic got;
    @(posedge clk); #2;
    pc = pc0; opcode = op; offset_in = off; start = 1'b1;
    {flag_n, flag_v, flag_c, flag_z} = fl;
    cyc = 1; got = 1'b0;
    for (int k = 0; k < 8 && !got; k++) begin
      @(posedge clk); #2;
      cyc++;
      start = (cyc == extra);
      {flag_n, flag_v, flag_c, flag_z} = ~fl;
      @(negedge clk);
      if (done) got = 1'b1;
    end
    @(posedge clk); #2;
    start = 1'b0;
    chk({name, "_done_seen"}, {15'd0, got}, 16'd1);
    chk({name, "_cycles"}, cyc[15:0], exp_cyc[15:0]);
    chk({name, "_pc"}, pc, exp_pc);
    chk({name, "_taken"}, {15'd0, taken}, {15'd0, exp_taken});
    chk({name, "_crossed"}, {15'd0, crossed}, {15'd0, exp_crossed});
    @(posedge clk); #2;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    run_branch("bne_taken", 8'hD0, 4'b0000, 16'h1210, 8'h05, 16'h1216, 3, 1'b1, 1'b0, 0);
    run_branch("beq_not", 8'hF0, 4'b0000, 16'h1210, 8'h05, 16'h1211, 2, 1'b0, 1'b0, 2);
    run_branch("bcc_fwd_cross", 8'h90, 4'b0000, 16'h12EF, 8'h20, 16'h1310, 4, 1'b1, 1'b1, 2);
    run_branch("bmi_back_cross", 8'h30, 4'b1000, 16'h1204, 8'hF0, 16'h11F5, 4, 1'b1, 1'b1, 0);
    run_branch("bpl_80", 8'h10, 4'b0000, 16'h127F, 8'h80, 16'h1200, 3, 1'b1, 1'b0, 3);
    run_branch("bvs_wrap", 8'h70, 4'b0100, 16'h12FF, 8'h03, 16'h1303, 3, 1'b1, 1'b0, 0);
    run_branch("bvc_not", 8'h50, 4'b0100, 16'h1300, 8'h40, 16'h1301, 2, 1'b0, 1'b0, 0);
    run_branch("bcs_back", 8'hB0, 4'b0010, 16'h1200, 8'hFE, 16'h11FF, 4, 1'b1, 1'b1, 0);

    // non-branch opcode with start
    @(posedge clk); #2;
    opcode = 8'hA9; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    @(negedge clk);
    chk("lda_ignored_busy", {15'd0, busy}, 16'd0);

    // reset asserted during FIX of a backward crossing BMI
    @(posedge clk); #2;
    pc = 16'h1204; opcode = 8'h30; offset_in = 8'hF0; start = 1'b1;
    {flag_n, flag_v, flag_c, flag_z} = 4'b1000;
    @(posedge clk); #2;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk); #3;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rstfix_h_dec", {15'd0, pc_h_dec}, 16'd0);
    chk("rstfix_state", {14'd0, dbg_state}, 16'd0);
    @(posedge clk); #2;
    chk("rstfix_pc", pc, 16'h12F5);
    rst_n = 1'b1;
    run_branch("post_rst_bne", 8'hD0, 4'b0000, 16'h2000, 8'h10, 16'h2011, 3, 1'b1, 1'b0, 0);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
